// File: rtl/m68k_region_decoder.sv
// Registered 68000 bus region decoder: runtime base/mask table, one-hot chip
// selects, programmable /DTACK wait states and /BERR timeout on unmapped accesses.
module m68k_region_decoder #(
  parameter int NUM_REGIONS = 16,
  parameter int ADDR_W      = 24,
  parameter int WAIT_W      = 4,
  parameter int BERR_CYCLES = 64,
  parameter int IDX_W       = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_mask,
  input  logic [NUM_REGIONS*WAIT_W-1:0] cfg_wait,
  input  logic [NUM_REGIONS-1:0]        cfg_en,
  input  logic [ADDR_W-1:0]             m68k_a,
  input  logic                          m68k_as_n,
  input  logic                          m68k_rw,
  output logic [NUM_REGIONS-1:0]        cs,
  output logic                          cs_rd,
  output logic                          cs_wr,
  output logic [IDX_W-1:0]              hit_idx,
  output logic                          m68k_dtack_n,
  output logic                          m68k_berr_n,
  output logic                          busy
);

  // Wide enough for both the wait-state load and the /BERR timeout, so it never wraps.
  localparam int CNT_W = (WAIT_W > $clog2(BERR_CYCLES)) ? WAIT_W : $clog2(BERR_CYCLES);
  localparam logic [CNT_W-1:0] BERR_LAST = CNT_W'(BERR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACK,
    S_NOHIT,
    S_BERR
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_REGIONS-1:0]   hit, sel_cs, cs_d;
  logic                     hit_any;
  logic [IDX_W-1:0]         hit_sel, idx_d;
  logic [WAIT_W-1:0]        sel_wait;
  logic                     rd_d, wr_d, dtack_d, berr_d, go_idle;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = cfg_en[i] &&
               (((m68k_a ^ cfg_base[i*ADDR_W +: ADDR_W]) & cfg_mask[i*ADDR_W +: ADDR_W]) == '0);
    end
  end

  // Lowest index wins on overlap; isolating the lowest set bit keeps cs one-hot.
  assign sel_cs = hit & ~(hit - NUM_REGIONS'(1));

  always_comb begin
    hit_any  = 1'b0;
    hit_sel  = '0;
    sel_wait = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any  = 1'b1;
        hit_sel  = IDX_W'(i);
        sel_wait = cfg_wait[i*WAIT_W +: WAIT_W];
      end
    end
  end

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs;
    rd_d    = cs_rd;
    wr_d    = cs_wr;
    idx_d   = hit_idx;
    dtack_d = m68k_dtack_n;
    berr_d  = m68k_berr_n;
    go_idle = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!m68k_as_n) begin
          if (hit_any) begin
            state_d = S_WAIT;
            cs_d    = sel_cs;
            rd_d    = m68k_rw;
            wr_d    = !m68k_rw;
            idx_d   = hit_sel;
            cnt_d   = CNT_W'(sel_wait);
          end else begin
            state_d = S_NOHIT;
            cnt_d   = '0;
          end
        end
      end
      // A strobe release always beats an expiring counter.
      S_WAIT: begin
        if (m68k_as_n) begin
          go_idle = 1'b1;
        end else if (cnt_q == '0) begin
          dtack_d = 1'b0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        if (m68k_as_n) go_idle = 1'b1;
      end
      S_NOHIT: begin
        if (m68k_as_n) begin
          go_idle = 1'b1;
        end else if (cnt_q == BERR_LAST) begin
          berr_d  = 1'b0;
          state_d = S_BERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BERR: begin
        if (m68k_as_n) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      cs_d    = '0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      idx_d   = '0;
      dtack_d = 1'b1;
      berr_d  = 1'b1;
    end
  end

  // NOTE: state and outputs use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cs           <= '0;
      cs_rd        <= 1'b0;
      cs_wr        <= 1'b0;
      hit_idx      <= '0;
      m68k_dtack_n <= 1'b1;
      m68k_berr_n  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cs           <= cs_d;
      cs_rd        <= rd_d;
      cs_wr        <= wr_d;
      hit_idx      <= idx_d;
      m68k_dtack_n <= dtack_d;
      m68k_berr_n  <= berr_d;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_m68k_region_decoder.sv
// Bench for m68k_region_decoder: directed bus cycles plus randomized tables and
// accesses, checked against a timeline model derived from the decode table.
module tb_m68k_region_decoder;

  localparam int NR = 16;
  localparam int AW = 24;
  localparam int WW = 4;
  localparam int BC = 64;
  localparam int IW = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR*AW-1:0]  cfg_base;
  logic [NR*AW-1:0]  cfg_mask;
  logic [NR*WW-1:0]  cfg_wait;
  logic [NR-1:0]     cfg_en;
  logic [AW-1:0]     m68k_a;
  logic              m68k_as_n;
  logic              m68k_rw;
  logic [NR-1:0]     cs;
  logic              cs_rd;
  logic              cs_wr;
  logic [IW-1:0]     hit_idx;
  logic              m68k_dtack_n;
  logic              m68k_berr_n;
  logic              busy;

  m68k_region_decoder #(
    .NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW), .BERR_CYCLES(BC), .IDX_W(IW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_wait(cfg_wait), .cfg_en(cfg_en),
    .m68k_a(m68k_a), .m68k_as_n(m68k_as_n), .m68k_rw(m68k_rw),
    .cs(cs), .cs_rd(cs_rd), .cs_wr(cs_wr), .hit_idx(hit_idx),
    .m68k_dtack_n(m68k_dtack_n), .m68k_berr_n(m68k_berr_n), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference decode table
  logic [AW-1:0] t_base[NR];
  logic [AW-1:0] t_mask[NR];
  logic [WW-1:0] t_wait[NR];
  logic          t_en[NR];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_table();
    for (int i = 0; i < NR; i++) begin
      cfg_base[i*AW +: AW] = t_base[i];
      cfg_mask[i*AW +: AW] = t_mask[i];
      cfg_wait[i*WW +: WW] = t_wait[i];
      cfg_en[i]            = t_en[i];
    end
  endtask

  task automatic clear_table();
    for (int i = 0; i < NR; i++) begin
      t_base[i] = '0;
      t_mask[i] = '0;
      t_wait[i] = '0;
      t_en[i]   = 1'b0;
    end
  endtask

  task automatic randomize_table();
    for (int i = 0; i < NR; i++) begin
      t_base[i] = AW'($urandom);
      t_mask[i] = AW'($urandom) | 24'hC00000;
      t_wait[i] = WW'($urandom);
      t_en[i]   = 1'($urandom_range(0, 1));
    end
  endtask

  // First enabled region whose compared bits equal the address, else -1.
  function automatic int model_region(input logic [AW-1:0] a);
    for (int i = 0; i < NR; i++)
      if (t_en[i] && ((a ^ t_base[i]) & t_mask[i]) == '0) return i;
    return -1;
  endfunction

  // Full bus cycle: decode, wait for dtack/berr, hold, release, idle gap.
  task automatic run_access(input logic [AW-1:0] a, input logic rw, input int hold,
                            input bit scramble);
    int r, w, n;
    bit seen;
    r = model_region(a);
    w = (r >= 0) ? int'(t_wait[r]) : 0;
    m68k_a    = a;
    m68k_rw   = rw;
    m68k_as_n = 1'b0;
    tick();
    // Inputs other than the strobe must be ignored once decoded.
    m68k_a  = AW'($urandom);
    m68k_rw = ~rw;
    if (scramble) begin
      randomize_table();
      apply_table();
    end
    if (r >= 0) begin
      check("decode_cs", 32'(cs), 32'(1) << r);
      check("decode_idx", 32'(hit_idx), 32'(r));
      check("decode_rdwr", {30'd0, cs_rd, cs_wr}, {30'd0, rw, ~rw});
      check("decode_busy", 32'(busy), 32'd1);
      n = 0;
      while (m68k_dtack_n === 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check("dtack_latency", n, w + 1);
      repeat (hold) tick();
      check("ack_hold", {15'd0, cs, m68k_dtack_n}, {15'd0, 16'(32'(1) << r), 1'b0});
      m68k_as_n = 1'b1;
      tick();
      check("ack_release", 32'({cs, cs_rd, cs_wr, busy, m68k_dtack_n, m68k_berr_n}),
            32'({16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));
    end else begin
      check("nohit_decode", 32'({cs, cs_rd, cs_wr, busy, m68k_berr_n}),
            32'({16'h0, 1'b0, 1'b0, 1'b1, 1'b1}));
      n    = 0;
      seen = 1'b0;
      while (m68k_berr_n === 1'b1 && n < 200) begin
        tick();
        n++;
        if (m68k_dtack_n !== 1'b1) seen = 1'b1;
      end
      check("berr_latency", n, BC);
      repeat (hold) tick();
      check("berr_hold", {30'd0, m68k_berr_n, seen}, 32'd0);
      m68k_as_n = 1'b1;
      tick();
      check("berr_release", 32'({cs, busy, m68k_dtack_n, m68k_berr_n}),
            32'({16'h0, 1'b0, 1'b1, 1'b1}));
    end
    tick();
  endtask

  // Strobe released after k clocks in WAIT/NOHIT (k may equal the expiry edge).
  task automatic run_abort(input logic [AW-1:0] a, input logic rw, input int k);
    bit seen;
    seen      = 1'b0;
    m68k_a    = a;
    m68k_rw   = rw;
    m68k_as_n = 1'b0;
    tick();
    repeat (k) begin
      tick();
      if (m68k_dtack_n !== 1'b1 || m68k_berr_n !== 1'b1) seen = 1'b1;
    end
    m68k_as_n = 1'b1;
    tick();
    check("abort_clear", 32'({cs, cs_rd, cs_wr, busy, m68k_dtack_n, m68k_berr_n}),
          32'({16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1}));
    check("abort_no_pulse", 32'(seen), 32'd0);
    tick();
  endtask

  initial begin
    int r, lim, n;
    logic [AW-1:0] a;

    reset_n   = 1'b0;
    m68k_as_n = 1'b1;
    m68k_rw   = 1'b1;
    m68k_a    = '0;
    clear_table();
    t_base[0] = 24'h000000; t_mask[0] = 24'hFC0000; t_wait[0] = 4'd0; t_en[0] = 1'b1;
    t_base[1] = 24'h040000; t_mask[1] = 24'hFFC000; t_wait[1] = 4'd2; t_en[1] = 1'b1;
    t_base[3] = 24'h300000; t_mask[3] = 24'hF00000; t_wait[3] = 4'd1; t_en[3] = 1'b1;
    t_base[5] = 24'h300000; t_mask[5] = 24'hFF0000; t_wait[5] = 4'd3; t_en[5] = 1'b1;
    apply_table();

    #22;
    check("reset_state", 32'({cs, cs_rd, cs_wr, hit_idx, busy, m68k_dtack_n, m68k_berr_n}),
          32'({16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1}));
    reset_n = 1'b1;
    tick();
    tick();

    run_access(24'h040010, 1'b1, 2, 1'b0);
    run_access(24'h01FFFE, 1'b1, 0, 1'b0);
    run_access(24'h300000, 1'b0, 1, 1'b0);
    run_access(24'h600000, 1'b0, 2, 1'b0);

    t_wait[1] = 4'd15;
    apply_table();
    run_abort(24'h040010, 1'b1, 5);
    run_abort(24'h040010, 1'b1, 15);
    run_abort(24'h600000, 1'b1, BC - 1);

    // Asynchronous reset while acknowledging
    t_wait[1] = 4'd2;
    apply_table();
    m68k_a    = 24'h040010;
    m68k_rw   = 1'b1;
    m68k_as_n = 1'b0;
    tick();
    n = 0;
    while (m68k_dtack_n === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("pre_reset_ack", {16'd0, cs}, 32'h0002);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 32'({cs, cs_rd, cs_wr, hit_idx, busy, m68k_dtack_n, m68k_berr_n}),
          32'({16'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1}));
    m68k_as_n = 1'b1;
    #1 reset_n = 1'b1;
    tick();
    run_access(24'h040010, 1'b0, 1, 1'b0);

    // Randomized tables and accesses
    for (int t = 0; t < 40; t++) begin
      if (t % 8 == 0) begin
        randomize_table();
        apply_table();
      end
      if ($urandom_range(0, 3) != 0) begin
        int j;
        j = $urandom_range(0, NR - 1);
        a = t_base[j] ^ (AW'($urandom) & ~t_mask[j]);
      end else begin
        a = AW'($urandom);
      end
      if ($urandom_range(0, 4) == 0) begin
        r   = model_region(a);
        lim = (r >= 0) ? int'(t_wait[r]) : BC - 1;
        run_abort(a, 1'($urandom), $urandom_range(0, lim));
      end else begin
        run_access(a, 1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
